// File: rtl/multadd_arbiter.sv
// Round-robin arbiter sharing one pipelined multiply-add core between two requesters.
// A tag pipeline steers each core result to its port's FIFO; credits guarantee FIFO space.
module multadd_arbiter #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned P_W        = 64,
  parameter int unsigned LATENCY    = 4,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic              CLK,
  input  logic              SCLR,
  input  logic              S0_VALID,
  output logic              S0_READY,
  input  logic [DATA_W-1:0] S0_A,
  input  logic [DATA_W-1:0] S0_B,
  input  logic [DATA_W-1:0] S0_C,
  input  logic              S0_SUB,
  input  logic              S1_VALID,
  output logic              S1_READY,
  input  logic [DATA_W-1:0] S1_A,
  input  logic [DATA_W-1:0] S1_B,
  input  logic [DATA_W-1:0] S1_C,
  input  logic              S1_SUB,
  output logic [DATA_W-1:0] MA_A,
  output logic [DATA_W-1:0] MA_B,
  output logic [DATA_W-1:0] MA_C,
  output logic              MA_SUBTRACT,
  input  logic [P_W-1:0]    MA_P,
  output logic              R0_VALID,
  input  logic              R0_READY,
  output logic [P_W-1:0]    R0_P,
  output logic              R1_VALID,
  input  logic              R1_READY,
  output logic [P_W-1:0]    R1_P,
  output logic              BUSY
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned STAGES = LATENCY + 1;

  logic              last_grant;
  logic [1:0]        elig, grant, wr, pop, res_ready;
  logic [CNT_W-1:0]  inflight [2];
  logic [CNT_W-1:0]  count [2];
  logic [CNT_W-1:0]  inflight_nxt [2];
  logic [CNT_W-1:0]  count_nxt [2];
  logic [PTR_W-1:0]  wptr [2];
  logic [PTR_W-1:0]  rptr [2];
  logic [P_W-1:0]    fifo_mem [2][FIFO_DEPTH];
  logic [STAGES-1:0] tag_v, tag_p;
  logic              busy_nxt;

  // Eligibility, round-robin grant and net counter updates
  always_comb begin
    res_ready = {R1_READY, R0_READY};
    elig      = {S1_VALID, S0_VALID};
    busy_nxt  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (({1'b0, inflight[i]} + {1'b0, count[i]}) >= (CNT_W+1)'(FIFO_DEPTH))
        elig[i] = 1'b0;
      wr[i]  = tag_v[STAGES-1] && (tag_p[STAGES-1] == 1'(i));
      pop[i] = (count[i] != '0) && res_ready[i];
    end
    grant = elig;
    if (elig == 2'b11)
      grant = last_grant ? 2'b01 : 2'b10;
    if (SCLR)
      grant = 2'b00;
    for (int i = 0; i < 2; i++) begin
      inflight_nxt[i] = inflight[i] + CNT_W'(grant[i]) - CNT_W'(wr[i]);
      count_nxt[i]    = count[i] + CNT_W'(wr[i]) - CNT_W'(pop[i]);
      if ((inflight_nxt[i] != '0) || (count_nxt[i] != '0))
        busy_nxt = 1'b1;
    end
  end

  assign S0_READY = grant[0];
  assign S1_READY = grant[1];
  assign R0_VALID = (count[0] != '0);
  assign R1_VALID = (count[1] != '0);
  assign R0_P     = R0_VALID ? fifo_mem[0][rptr[0]] : '0;
  assign R1_P     = R1_VALID ? fifo_mem[1][rptr[1]] : '0;

  // Operand registers, tag pipeline, counters and pointers
  always_ff @(posedge CLK) begin
    if (SCLR) begin
      last_grant  <= 1'b1;
      MA_A        <= '0;
      MA_B        <= '0;
      MA_C        <= '0;
      MA_SUBTRACT <= 1'b0;
      tag_v       <= '0;
      tag_p       <= '0;
      BUSY        <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        inflight[i] <= '0;
        count[i]    <= '0;
        wptr[i]     <= '0;
        rptr[i]     <= '0;
      end
    end else begin
      if (grant != 2'b00) begin
        last_grant  <= grant[1];
        MA_A        <= grant[1] ? S1_A : S0_A;
        MA_B        <= grant[1] ? S1_B : S0_B;
        MA_C        <= grant[1] ? S1_C : S0_C;
        MA_SUBTRACT <= grant[1] ? S1_SUB : S0_SUB;
      end
      tag_v <= {tag_v[STAGES-2:0], (grant != 2'b00)};
      tag_p <= {tag_p[STAGES-2:0], grant[1]};
      BUSY  <= busy_nxt;
      for (int i = 0; i < 2; i++) begin
        inflight[i] <= inflight_nxt[i];
        count[i]    <= count_nxt[i];
        if (wr[i])
          wptr[i] <= wptr[i] + PTR_W'(1);
        if (pop[i])
          rptr[i] <= rptr[i] + PTR_W'(1);
      end
    end
  end

  // Result storage; contents are don't-care until written, so no reset
  always_ff @(posedge CLK) begin
    for (int i = 0; i < 2; i++)
      if (wr[i])
        fifo_mem[i][wptr[i]] <= MA_P;
  end

  // Credits make an unpopped write into a full FIFO impossible
  always_ff @(posedge CLK) begin
    if (!SCLR)
      for (int i = 0; i < 2; i++)
        assert (!(wr[i] && !pop[i] && (count[i] == CNT_W'(FIFO_DEPTH))));
  end

endmodule

// File: tb/tb_multadd_arbiter.sv
// Bench for multadd_arbiter: behavioural multiply-add core, per-port expected-result queues,
// directed scenarios followed by randomized traffic.
module tb_multadd_arbiter;

  localparam int unsigned LAT   = 4;
  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        sclr;
  logic        s_valid [2];
  logic        s_ready [2];
  logic [31:0] s_a [2];
  logic [31:0] s_b [2];
  logic [31:0] s_c [2];
  logic        s_sub [2];
  logic [31:0] ma_a, ma_b, ma_c;
  logic        ma_sub;
  logic [63:0] ma_p;
  logic        r_valid [2];
  logic        r_ready [2];
  logic [63:0] r_p [2];
  logic        busy;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] q0 [$];
  logic [63:0] q1 [$];
  logic [1:0]  last_acc;
  int          gen_mode [2];
  logic [31:0] seq [2];
  logic [63:0] core_pipe [LAT];

  multadd_arbiter #(.DATA_W(32), .P_W(64), .LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .CLK(clk), .SCLR(sclr),
    .S0_VALID(s_valid[0]), .S0_READY(s_ready[0]), .S0_A(s_a[0]), .S0_B(s_b[0]),
    .S0_C(s_c[0]), .S0_SUB(s_sub[0]),
    .S1_VALID(s_valid[1]), .S1_READY(s_ready[1]), .S1_A(s_a[1]), .S1_B(s_b[1]),
    .S1_C(s_c[1]), .S1_SUB(s_sub[1]),
    .MA_A(ma_a), .MA_B(ma_b), .MA_C(ma_c), .MA_SUBTRACT(ma_sub), .MA_P(ma_p),
    .R0_VALID(r_valid[0]), .R0_READY(r_ready[0]), .R0_P(r_p[0]),
    .R1_VALID(r_valid[1]), .R1_READY(r_ready[1]), .R1_P(r_p[1]),
    .BUSY(busy)
  );

  always #5 clk = ~clk;

  // Expected multiply-add result, unsigned, modulo 2^64
  function automatic logic [63:0] ref_p(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c, input logic sub);
    logic [63:0] prod;
    prod = 64'(a) * 64'(b);
    return sub ? prod - 64'(c) : prod + 64'(c);
  endfunction

  // Behavioural core: result appears LAT cycles after operands
  always @(posedge clk) begin
    if (sclr) begin
      for (int k = 0; k < LAT; k++) core_pipe[k] <= '0;
    end else begin
      core_pipe[0] <= ref_p(ma_a, ma_b, ma_c, ma_sub);
      for (int k = 1; k < LAT; k++) core_pipe[k] <= core_pipe[k-1];
    end
  end
  assign ma_p = core_pipe[LAT-1];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present the next request per port after an accept (or when idle)
  task automatic refill(input logic [1:0] acc);
    for (int i = 0; i < 2; i++) begin
      if (acc[i] || !s_valid[i]) begin
        case (gen_mode[i])
          1: begin
            if (acc[i]) seq[i] = seq[i] + 32'd1;
            s_valid[i] = 1'b1;
            s_a[i] = seq[i]; s_b[i] = 32'd1; s_c[i] = 32'd0; s_sub[i] = 1'b0;
          end
          2: begin
            s_valid[i] = ($urandom_range(3) != 0);
            s_a[i] = $urandom; s_b[i] = $urandom; s_c[i] = $urandom;
            s_sub[i] = 1'($urandom_range(1));
          end
          default: s_valid[i] = 1'b0;
        endcase
      end
    end
  endtask

  // One clock: observe accepts/pops just after the negedge, then advance
  task automatic tick();
    logic [1:0]  acc;
    logic [63:0] exp;
    #1;
    for (int i = 0; i < 2; i++) acc[i] = s_valid[i] && s_ready[i];
    if (acc[0]) q0.push_back(ref_p(s_a[0], s_b[0], s_c[0], s_sub[0]));
    if (acc[1]) q1.push_back(ref_p(s_a[1], s_b[1], s_c[1], s_sub[1]));
    if (r_valid[0] && r_ready[0]) begin
      if (q0.size() == 0) chk("spurious_r0", 64'(r_valid[0]), 64'd0);
      else begin exp = q0.pop_front(); chk("result_r0", r_p[0], exp); end
    end
    if (r_valid[1] && r_ready[1]) begin
      if (q1.size() == 0) chk("spurious_r1", 64'(r_valid[1]), 64'd0);
      else begin exp = q1.pop_front(); chk("result_r1", r_p[1], exp); end
    end
    chk("one_accept", 64'(acc[0] & acc[1]), 64'd0);
    last_acc = acc;
    @(posedge clk);
    @(negedge clk);
    refill(acc);
  endtask

  task automatic drain(input string tag);
    gen_mode[0] = 0; gen_mode[1] = 0;
    r_ready[0] = 1'b1; r_ready[1] = 1'b1;
    for (int k = 0; k < 200; k++) begin
      if (q0.size() == 0 && q1.size() == 0 && !busy && !s_valid[0] && !s_valid[1]) break;
      tick();
    end
    chk({tag, "_q0_empty"}, 64'(q0.size()), 64'd0);
    chk({tag, "_q1_empty"}, 64'(q1.size()), 64'd0);
    chk({tag, "_busy_low"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int  lat, n0, resume;
    logic seen1;

    // Reset held with both requesters valid
    sclr = 1'b1;
    gen_mode[0] = 0; gen_mode[1] = 0;
    seq[0] = 32'd1; seq[1] = 32'd1;
    r_ready[0] = 1'b0; r_ready[1] = 1'b0;
    s_valid[0] = 1'b1; s_a[0] = 32'h0001_0000; s_b[0] = 32'h0001_0000;
    s_c[0] = 32'h0002_0000; s_sub[0] = 1'b0;
    s_valid[1] = 1'b1; s_a[1] = 32'd7; s_b[1] = 32'd9; s_c[1] = 32'd1; s_sub[1] = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      chk("rst_ready", {62'd0, s_ready[1], s_ready[0]}, 64'd0);
      chk("rst_rvalid", {62'd0, r_valid[1], r_valid[0]}, 64'd0);
      chk("rst_rp", r_p[0] | r_p[1], 64'd0);
      chk("rst_ma", {ma_a | ma_b | ma_c, 31'd0, ma_sub}, 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      if (k < 4) begin @(posedge clk); @(negedge clk); end
    end
    sclr = 1'b0;
    #1;
    chk("post_rst_s0_ready", 64'(s_ready[0]), 64'd1);
    chk("post_rst_s1_ready", 64'(s_ready[1]), 64'd0);

    // Single operation on port 0, latency measured from the accepting edge
    s_valid[1] = 1'b0;
    tick();
    chk("single_accept", 64'(last_acc), 64'd1);
    lat = 0; seen1 = 1'b0;
    for (int k = 1; k <= LAT + 6; k++) begin
      if (r_valid[0] && lat == 0) begin
        lat = k;
        chk("single_r0_p", r_p[0], 64'h0000_0001_0002_0000);
      end
      if (r_valid[1]) seen1 = 1'b1;
      @(posedge clk); @(negedge clk);
    end
    chk("single_latency", 64'(lat), 64'(LAT + 2));
    chk("single_no_r1", 64'(seen1), 64'd0);
    drain("single");

    // Subtract on port 1, operands registered toward the core
    s_valid[1] = 1'b1; s_a[1] = 32'd3; s_b[1] = 32'd5; s_c[1] = 32'd100; s_sub[1] = 1'b1;
    tick();
    chk("sub_accept", 64'(last_acc), 64'd2);
    chk("sub_ma_a", 64'(ma_a), 64'd3);
    chk("sub_ma_b", 64'(ma_b), 64'd5);
    chk("sub_ma_c", 64'(ma_c), 64'd100);
    chk("sub_ma_sub", 64'(ma_sub), 64'd1);
    tick();
    chk("ma_hold", 64'(ma_a), 64'd3);
    drain("sub");

    // Fairness: both streaming, grants alternate starting with port 0
    gen_mode[0] = 1; gen_mode[1] = 1; seq[0] = 32'd1; seq[1] = 32'd1;
    r_ready[0] = 1'b1; r_ready[1] = 1'b1;
    refill(2'b00);
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("fair_grant", 64'(last_acc), (k % 2 == 0) ? 64'd1 : 64'd2);
    end
    chk("fair_busy", 64'(busy), 64'd1);
    drain("fair");

    // Backpressure on port 0: exactly DEPTH accepts, then port 1 every cycle
    gen_mode[0] = 1; gen_mode[1] = 1; seq[0] = 32'd1; seq[1] = 32'd1;
    r_ready[0] = 1'b0; r_ready[1] = 1'b1;
    refill(2'b00);
    n0 = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      n0 += int'(last_acc[0]);
      if (k >= 20) chk("bp_p1_only", 64'(last_acc), 64'd2);
    end
    chk("bp_p0_accepts", 64'(n0), 64'(DEPTH));
    chk("bp_s0_ready_low", 64'(s_ready[0]), 64'd0);
    r_ready[0] = 1'b1;
    resume = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      resume += int'(last_acc[0]);
    end
    chk("bp_resume", 64'(resume != 0), 64'd1);
    drain("bp");

    // Reset mid-flight: three port-1 ops discarded, credits restored
    r_ready[1] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      s_valid[1] = 1'b1; s_a[1] = 32'(k + 10); s_b[1] = 32'd2; s_c[1] = 32'd0; s_sub[1] = 1'b0;
      tick();
      chk("mid_accept", 64'(last_acc), 64'd2);
    end
    tick();
    tick();
    sclr = 1'b1;
    tick();
    sclr = 1'b0;
    q1.delete();
    for (int k = 0; k < LAT + 6; k++) begin
      chk("mid_no_r1", 64'(r_valid[1]), 64'd0);
      chk("mid_busy", 64'(busy), 64'd0);
      tick();
    end
    gen_mode[1] = 1; seq[1] = 32'd1;
    refill(2'b00);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("mid_no_stall", 64'(last_acc), 64'd2);
    end
    drain("mid");

    // Randomized traffic with random result backpressure
    gen_mode[0] = 2; gen_mode[1] = 2;
    refill(2'b00);
    for (int k = 0; k < 400; k++) begin
      r_ready[0] = ($urandom_range(3) != 0);
      r_ready[1] = ($urandom_range(3) != 0);
      tick();
    end
    drain("rand");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multadd_arbiter.md
# multadd_arbiter

Shares one pipelined multiply-add core (the `xbip_multadd` instance in the noise generator) between two requesters. Each requester submits A/B/C operands over a valid/ready handshake and gets its products back in order. Arbitration is round-robin. Operands are registered into the core, and a tag pipeline steers each core output to the issuing port's result FIFO. Per-port credits make sure a result always has FIFO space when it emerges.

## Interface
Parameters:
- DATA_W, 32, operand width of A, B, C
- P_W, 64, width of core result P
- LATENCY, 4, cycles from operands valid on MA_A/B/C to matching MA_P valid (must equal core configuration, ≥1)
- FIFO_DEPTH, 8, per-port result FIFO depth and credit limit (power of 2, ≥2)

Ports:
- CLK  in  1  clock
- SCLR  in  1  synchronous active-high reset
- S0_VALID / S1_VALID  in  1  operand request valid
- S0_READY / S1_READY  out  1  request accepted this cycle
- S0_A, S0_B, S0_C / S1_A, S1_B, S1_C  in  DATA_W  operands
- S0_SUB / S1_SUB  in  1  subtract select for this operation
- MA_A, MA_B, MA_C  out  DATA_W  registered operands to core
- MA_SUBTRACT  out  1  registered subtract select to core
- MA_P  in  P_W  core result
- R0_VALID / R1_VALID  out  1  result available (FIFO head)
- R0_READY / R1_READY  in  1  result consumed
- R0_P / R1_P  out  P_W  result data
- BUSY  out  1  any operation in flight or any result FIFO non-empty

## Operation
- Credits per port i: used_i = inflight_i + fifo_count_i. Port i is eligible when Si_VALID && used_i < FIFO_DEPTH.
- Round-robin pointer last_grant resets to 1, so port 0 wins the first tie. If both ports are eligible, the port ≠ last_grant is granted. If one is eligible, it is granted. last_grant updates only on an accept.
- Si_READY = grant_i, combinational from eligibility and pointer. At most one accept per cycle. Si_READY is forced 0 while SCLR=1. Requesters must hold operands stable until accepted.
- On accept: the granted port's A, B, C, SUB are registered into MA_A/B/C/MA_SUBTRACT. With no accept, the MA_* registers hold their last value. A tag {valid=1, port} enters a (LATENCY+1)-stage shift register; otherwise a bubble (valid=0) enters.
- Tag output valid at stage LATENCY+1: MA_P is written to the tagged port's FIFO, inflight_port decrements and fifo_count_port increments in the same cycle.
- FIFO: Ri_VALID = fifo_count_i ≠ 0. Ri_P = head. Pop on Ri_VALID && Ri_READY.
  - Write and pop in the same cycle are legal, including at count = FIFO_DEPTH−1 and at FIFO_DEPTH. The count is then unchanged.
- Accept, tag-out and pop may all hit the same port in one cycle. The counters update by net sum.
- Write to a full FIFO is unreachable by construction. A simulation assertion flags it.
- Results per port are in issue order. Ports are independent; port 0 backpressure never blocks port 1 beyond its own credits.
- SCLR mid-operation:
  - Clears tags, FIFOs, counters and the pointer. In-flight core results are discarded; their MA_P values arrive with tag valid=0 and are ignored.
  - Core SCLR is driven externally from the same reset.

## Timing
- Reset values: S0/S1_READY 0, R0/R1_VALID 0, R0/R1_P 0, MA_A/B/C 0, MA_SUBTRACT 0, BUSY 0, last_grant 1.
- Accept at edge of cycle t → MA_* valid in cycle t+1 → MA_P valid in cycle t+1+LATENCY → FIFO written at that edge → Ri_VALID high in cycle t+2+LATENCY.
  - Request-to-result latency is LATENCY+2 cycles.
- Credit round trip with Ri_READY held high is LATENCY+3 cycles. One port sustains 1 op/cycle when FIFO_DEPTH ≥ LATENCY+3; defaults (8 ≥ 7) meet this.
- Aggregate issue rate is at most 1 op/cycle.
- BUSY is registered: high the cycle after any accept until the cycle after the last FIFO empties.

## Test plan
- Reset: hold SCLR 5 cycles with S0/S1_VALID=1 → all READY/VALID stay 0, MA_* = 0, BUSY = 0. First cycle after release: S0_READY = 1, S1_READY = 0.
- Single op: port 0 with A=0x00010000, B=0x00010000, C=0x00020000, SUB=0 (behavioural core P=A*B+C) → R0_VALID rises exactly LATENCY+2 cycles after accept, R0_P = 0x0000000100020000, no R1_VALID.
- Fairness: both ports valid continuously with R_READY=1 and streams A=1,2,3… → grants alternate 0,1,0,1 starting with 0, one accept per cycle, each port's results in ascending order.
- Backpressure: R0_READY=0 with both ports streaming → port 0 gets exactly 8 accepts, then S0_READY stays 0 and port 1 takes every cycle. Raising R0_READY drains 8 results in order and port 0 resumes.
- Reset mid-flight: 3 ops accepted on port 1, SCLR pulsed 1 cycle 2 cycles later → no R1_VALID afterwards, BUSY 0, and port 1 accepts 8 new ops without stall.
- Subtract/pass-through: S1_SUB=1, A=3, B=5, C=100 → cycle after accept MA_A=3, MA_B=5, MA_C=100, MA_SUBTRACT=1. The returned R1_P equals the core output sampled LATENCY cycles later.
